// File: rtl/uart_rx_word_packer_pkg.sv
// Shared definitions for the UART receive word packer: packer FSM states,
// word width, default inter-byte timeout and the byte-lane insert helper.
package uart_rx_word_packer_pkg;

    localparam int WORD_W                 = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } pack_state_e;

    // Returns the word with one byte lane replaced; lane 0 is the least significant byte.
    function automatic logic [WORD_W-1:0] insert_byte(
        input logic [WORD_W-1:0] word_in,
        input logic [7:0]        data_in,
        input logic [1:0]        lane
    );
        logic [WORD_W-1:0] res;
        res = word_in;
        case (lane)
            2'd0:    res[7:0]   = data_in;
            2'd1:    res[15:8]  = data_in;
            2'd2:    res[23:16] = data_in;
            2'd3:    res[31:24] = data_in;
            default: res        = word_in;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous first-word-fall-through FIFO with flush. A push while full is
// accepted only when a pop happens in the same cycle; otherwise it is ignored.
module uart_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     I_clk,
    input  logic                     I_rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign do_pop_s  = pop & ~empty_s;
    assign do_push_s = push & (~full_s | do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge I_clk) begin
        if (I_rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents only matter while covered by the occupancy count.
    always_ff @(posedge I_clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Head word is forced to zero while the FIFO is empty.
    always_comb begin
        if (empty_s) begin
            pop_data = {WIDTH{1'b0}};
        end else begin
            pop_data = mem_r[rd_ptr_r];
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs UART receive bytes into little-endian 32-bit words, discards partial
// words on inter-byte timeout and queues completed words in a small FWFT FIFO.
module uart_rx_word_packer
    import uart_rx_word_packer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
    input  logic                          I_rx_done,
    input  logic [7:0]                    I_rx_data,
    input  logic                          I_flush,
    input  logic                          I_clr_overflow,
    output logic                          O_word_valid,
    output logic [WORD_W-1:0]             O_word_data,
    input  logic                          I_word_ready,
    output logic [1:0]                    O_byte_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   O_fill,
    output logic                          O_overflow,
    output logic                          O_timeout
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

    pack_state_e       state_r,   state_nxt_s;
    logic [1:0]        cnt_r,     cnt_nxt_s;
    logic [WORD_W-1:0] word_r,    word_nxt_s;
    logic [TMO_W-1:0]  tmo_r,     tmo_nxt_s;
    logic              rx_done_q_r;
    logic              timeout_r;
    logic              overflow_r;
    logic              byte_ev_s;
    logic              push_s;
    logic              pop_s;
    logic              expire_s;
    logic              drop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [WORD_W-1:0] fifo_data_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;

    assign byte_ev_s = I_rx_done & ~rx_done_q_r;
    assign pop_s     = ~fifo_empty_s & I_word_ready & ~I_flush;
    assign drop_s    = push_s & fifo_full_s & ~pop_s;

    // State, partial word and timeout counter registers.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= 2'd0;
            word_r      <= {WORD_W{1'b0}};
            tmo_r       <= {TMO_W{1'b0}};
            rx_done_q_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            word_r      <= word_nxt_s;
            tmo_r       <= tmo_nxt_s;
            rx_done_q_r <= I_rx_done;
        end
    end

    // Packer next-state: a byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        word_nxt_s  = word_r;
        tmo_nxt_s   = tmo_r;
        push_s      = 1'b0;
        expire_s    = 1'b0;
        if (I_flush) begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = 2'd0;
            word_nxt_s  = {WORD_W{1'b0}};
            tmo_nxt_s   = {TMO_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    tmo_nxt_s = {TMO_W{1'b0}};
                    if (byte_ev_s) begin
                        word_nxt_s  = {{(WORD_W-8){1'b0}}, I_rx_data};
                        cnt_nxt_s   = 2'd1;
                        state_nxt_s = S_COLLECT;
                    end else begin
                        cnt_nxt_s   = 2'd0;
                    end
                end
                S_COLLECT: begin
                    if (byte_ev_s) begin
                        word_nxt_s = insert_byte(word_r, I_rx_data, cnt_r);
                        tmo_nxt_s  = {TMO_W{1'b0}};
                        if (cnt_r == 2'd3) begin
                            push_s      = 1'b1;
                            cnt_nxt_s   = 2'd0;
                            state_nxt_s = S_IDLE;
                        end else begin
                            cnt_nxt_s   = cnt_r + 2'd1;
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        expire_s    = 1'b1;
                        cnt_nxt_s   = 2'd0;
                        tmo_nxt_s   = {TMO_W{1'b0}};
                        state_nxt_s = S_IDLE;
                    end else if (tmo_r != TMO_MAX) begin
                        tmo_nxt_s   = tmo_r + TMO_W'(1);
                    end else begin
                        tmo_nxt_s   = tmo_r;
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = 2'd0;
                    tmo_nxt_s   = {TMO_W{1'b0}};
                end
            endcase
        end
    end

    // Timeout pulse and sticky overflow; a new drop beats a same-cycle clear.
    always_ff @(posedge I_clk) begin
        if (I_rst || I_flush) begin
            timeout_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            timeout_r <= expire_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (I_clr_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    uart_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .I_clk     (I_clk),
        .I_rst     (I_rst),
        .flush     (I_flush),
        .push      (push_s),
        .push_data (word_nxt_s),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign O_word_valid = ~fifo_empty_s;
    assign O_word_data  = fifo_data_s;
    assign O_byte_cnt   = cnt_r;
    assign O_fill       = fifo_count_s;
    assign O_overflow   = overflow_r;
    assign O_timeout    = timeout_r;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Scoreboard bench for uart_rx_word_packer: expected words are queued as the
// fourth byte is driven and compared whenever the consumer takes a word.
module tb_uart_rx_word_packer;

    logic        clk;
    logic        I_rst;
    logic        I_rx_done;
    logic [7:0]  I_rx_data;
    logic        I_flush;
    logic        I_clr_overflow;
    logic        O_word_valid;
    logic [31:0] O_word_data;
    logic        I_word_ready;
    logic [1:0]  O_byte_cnt;
    logic [2:0]  O_fill;
    logic        O_overflow;
    logic        O_timeout;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [31:0] words [5] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                               32'h100F0E0D, 32'h14131211};

    uart_rx_word_packer #(
        .TIMEOUT_CYCLES (50),
        .FIFO_DEPTH     (4)
    ) dut (
        .I_clk          (clk),
        .I_rst          (I_rst),
        .I_rx_done      (I_rx_done),
        .I_rx_data      (I_rx_data),
        .I_flush        (I_flush),
        .I_clr_overflow (I_clr_overflow),
        .O_word_valid   (O_word_valid),
        .O_word_data    (O_word_data),
        .I_word_ready   (I_word_ready),
        .O_byte_cnt     (O_byte_cnt),
        .O_fill         (O_fill),
        .O_overflow     (O_overflow),
        .O_timeout      (O_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Consumer side: every accepted word is checked against the scoreboard head.
    always @(negedge clk) begin
        if (I_rst === 1'b0 && I_flush === 1'b0 && O_word_valid === 1'b1 && I_word_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got word %h, required no word", O_word_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (O_word_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_word: got %h, required %h", O_word_data, exp_w);
                end
            end
        end
        if (O_word_valid === 1'b0) begin
            n_checks++;
            if (O_word_data !== 32'h0) begin
                n_fail++;
                $display("FAIL data_idle_zero: got %h, required 00000000", O_word_data);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        I_rx_done = 1'b1;
        I_rx_data = b;
        step(1);
        I_rx_done = 1'b0;
        step(1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_kept);
        if (expect_kept) exp_q.push_back(w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic test_reset;
        I_rst = 1'b1;
        step(3);
        @(negedge clk);
        n_checks++;
        if ({O_word_valid, O_word_data, O_byte_cnt, O_fill, O_overflow, O_timeout} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d f=%0d o=%b t=%b, required all 0",
                     O_word_valid, O_word_data, O_byte_cnt, O_fill, O_overflow, O_timeout);
        end
        step(1);
        I_rst = 1'b0;
        step(2);
    endtask

    task automatic test_basic_word;
        logic [7:0] bytes_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [1:0] cnt_exp [3] = '{2'd1, 2'd2, 2'd3};
        int vcount = 0;
        I_word_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes_v[i]);
            @(negedge clk);
            n_checks++;
            if (O_byte_cnt !== cnt_exp[i]) begin
                n_fail++;
                $display("FAIL basic_cnt: got %0d, required %0d", O_byte_cnt, cnt_exp[i]);
            end
        end
        exp_q.push_back(32'h44332211);
        I_rx_done = 1'b1;
        I_rx_data = bytes_v[3];
        step(1);
        I_rx_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (O_word_valid) vcount++;
        end
        n_checks++;
        if (vcount != 1) begin
            n_fail++;
            $display("FAIL basic_valid_pulse: got %0d valid cycles, required 1", vcount);
        end
        n_checks++;
        if (O_byte_cnt !== 2'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_done: got cnt=%0d pending=%0d, required 0 0", O_byte_cnt, exp_q.size());
        end
        step(1);
    endtask

    task automatic test_timeout;
        int pulses = 0;
        int edge_at = -1;
        send_byte(8'h11);
        send_byte(8'h22);
        // The second byte was captured one posedge before the current one.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (O_timeout === 1'b1) begin
                pulses++;
                edge_at = i + 1;
            end
        end
        n_checks++;
        if (pulses != 1 || edge_at != 50) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %0d pulses at edge %0d, required 1 at edge 50", pulses, edge_at);
        end
        n_checks++;
        if (O_byte_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL timeout_cnt: got %0d, required 0", O_byte_cnt);
        end
        step(1);
        send_word(32'hDDCCBBAA, 1'b1);
        step(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_next_word: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_overflow;
        I_word_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_word(words[i], i < 4);
        @(negedge clk);
        n_checks++;
        if (O_fill !== 3'd4 || O_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got fill=%0d ovf=%b, required 4 1", O_fill, O_overflow);
        end
        step(1);
        I_word_ready = 1'b1;
        step(8);
        I_word_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (O_fill !== 3'd0 || exp_q.size() != 0 || O_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drain: got fill=%0d pending=%0d ovf=%b, required 0 0 1",
                     O_fill, exp_q.size(), O_overflow);
        end
        step(1);
        I_clr_overflow = 1'b1;
        step(1);
        I_clr_overflow = 1'b0;
        @(negedge clk);
        n_checks++;
        if (O_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b, required 0", O_overflow);
        end
        step(1);
    endtask

    task automatic test_full_push_pop;
        logic [31:0] w5 = 32'hA4A3A2A1;
        I_word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(words[i], 1'b1);
        for (int b = 0; b < 3; b++) send_byte(w5[8*b +: 8]);
        exp_q.push_back(w5);
        I_rx_done    = 1'b1;
        I_rx_data    = w5[31:24];
        I_word_ready = 1'b1;
        step(1);
        I_rx_done    = 1'b0;
        I_word_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (O_fill !== 3'd4 || O_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pushpop: got fill=%0d ovf=%b, required 4 0", O_fill, O_overflow);
        end
        step(1);
        I_word_ready = 1'b1;
        step(8);
        I_word_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (O_fill !== 3'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_pushpop_drain: got fill=%0d pending=%0d, required 0 0", O_fill, exp_q.size());
        end
        step(1);
    endtask

    task automatic test_held_done;
        I_rx_done = 1'b1;
        I_rx_data = 8'h5A;
        step(10);
        I_rx_done = 1'b0;
        step(1);
        @(negedge clk);
        n_checks++;
        if (O_byte_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL held_done: got cnt=%0d, required 1", O_byte_cnt);
        end
        step(1);
    endtask

    task automatic test_flush_reset;
        send_byte(8'h77);
        @(negedge clk);
        n_checks++;
        if (O_byte_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_pre_cnt: got %0d, required 2", O_byte_cnt);
        end
        step(1);
        I_flush = 1'b1;
        step(1);
        I_flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (O_byte_cnt !== 2'd0 || O_fill !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_midword: got cnt=%0d fill=%0d, required 0 0", O_byte_cnt, O_fill);
        end
        step(1);
        send_word(words[0], 1'b1);
        send_word(words[1], 1'b1);
        @(negedge clk);
        n_checks++;
        if (O_fill !== 3'd2) begin
            n_fail++;
            $display("FAIL flush_pre_fill: got %0d, required 2", O_fill);
        end
        step(1);
        I_flush = 1'b1;
        exp_q.delete();
        step(1);
        I_flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (O_byte_cnt !== 2'd0 || O_fill !== 3'd0 || O_word_valid !== 1'b0 || O_word_data !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_queued: got cnt=%0d fill=%0d v=%b d=%h, required 0 0 0 00000000",
                     O_byte_cnt, O_fill, O_word_valid, O_word_data);
        end
        step(1);
        for (int i = 0; i < 5; i++) send_word(words[i], 1'b0);
        send_byte(8'hE1);
        send_byte(8'hE2);
        I_rst = 1'b1;
        step(1);
        I_rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({O_word_valid, O_word_data, O_byte_cnt, O_fill, O_overflow, O_timeout} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_midword: got v=%b d=%h c=%0d f=%0d o=%b t=%b, required all 0",
                     O_word_valid, O_word_data, O_byte_cnt, O_fill, O_overflow, O_timeout);
        end
        step(2);
    endtask

    initial begin
        I_rst          = 1'b1;
        I_rx_done      = 1'b0;
        I_rx_data      = 8'h00;
        I_flush        = 1'b0;
        I_clr_overflow = 1'b0;
        I_word_ready   = 1'b0;
        test_reset();
        test_basic_word();
        test_timeout();
        test_overflow();
        test_full_push_pop();
        test_held_done();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
